// File: rtl/s2p_frame_rx.sv
`default_nettype none
// ============================================================================
// Module   : s2p_frame_rx
// Purpose  : Serial-to-parallel frame receiver. Hunts for the 2-bit frame
//            header in an MSB-first bit stream, aligns to WIDTH-bit frame
//            boundaries, reassembles each frame into a parallel word and
//            tracks frame lock (LOCK_CNT good headers to lock, MISS_MAX
//            consecutive bad headers to lose it).
// Ports    : clk          - bit clock (shared with the serializer)
//            rst          - asynchronous active-high reset
//            din          - serial data bit, frame MSB first
//            din_valid    - din carries a valid bit this cycle
//            dout         - last accepted frame (header included)
//            dout_valid   - one-cycle pulse, dout updated
//            sync_locked  - frame alignment established
//            frame_err    - one-cycle pulse, header mismatch at frame end
//            parity_err   - one-cycle pulse, parity failure
// Options  : S2P_FRAME_PARITY_EN - when defined, frame bit 0 is an even
//            parity bit over bits [WIDTH-1:1]; good-header frames with bad
//            parity pulse parity_err and are dropped. When undefined,
//            bit 0 is plain data and parity_err is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module s2p_frame_rx #(
  parameter int         WIDTH    = 16,
  parameter logic [1:0] HDR      = 2'b11,
  parameter int         LOCK_CNT = 2,
  parameter int         MISS_MAX = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_valid,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             sync_locked,
  output logic             frame_err,
  output logic             parity_err
);

  localparam int             CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);
  localparam logic [2:0]     LOCK_C   = 3'(LOCK_CNT);
  localparam logic [2:0]     MISS_C   = 3'(MISS_MAX);

  typedef enum logic [0:0] {
    S_HUNT    = 1'b0,
    S_COLLECT = 1'b1
  } state_t;

  state_t           state_q;
  logic [WIDTH-2:0] sr_q;        // older bits; the incoming bit completes the word
  logic [CW-1:0]    cnt_q;       // HUNT: bits seen (0/1); COLLECT: bit position
  logic [2:0]       good_q;
  logic [2:0]       miss_q;
  logic             lock_q;      // internal lock, mirrored to sync_locked one cycle later
  logic [WIDTH-1:0] word_q;      // completed frame awaiting presentation
  logic             ev_good_q;   // frame-end verdicts, presented on the next edge
  logic             ev_ferr_q;
  logic [WIDTH-1:0] dout_q;
  logic             dout_valid_q;
  logic             sync_locked_q;
  logic             frame_err_q;

  logic [WIDTH-1:0] shift_d;
  logic             hdr_ok_d;
  logic [2:0]       good_inc_d;

  assign shift_d    = {sr_q, din};
  assign hdr_ok_d   = (shift_d[WIDTH-1:WIDTH-2] == HDR);
  assign good_inc_d = (good_q == LOCK_C) ? good_q : good_q + 3'd1;

`ifdef S2P_FRAME_PARITY_EN
  logic ev_perr_q;
  logic parity_err_q;
  logic par_ok_d;
  // Even parity over the whole frame (data bits plus the parity bit).
  assign par_ok_d = ~(^shift_d);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_HUNT;
      sr_q          <= '0;
      cnt_q         <= '0;
      good_q        <= '0;
      miss_q        <= '0;
      lock_q        <= 1'b0;
      word_q        <= '0;
      ev_good_q     <= 1'b0;
      ev_ferr_q     <= 1'b0;
      dout_q        <= '0;
      dout_valid_q  <= 1'b0;
      sync_locked_q <= 1'b0;
      frame_err_q   <= 1'b0;
`ifdef S2P_FRAME_PARITY_EN
      ev_perr_q     <= 1'b0;
      parity_err_q  <= 1'b0;
`endif
    end else begin
      // Output stage: verdicts made on the last bit's edge appear one edge later.
      ev_good_q     <= 1'b0;
      ev_ferr_q     <= 1'b0;
      dout_valid_q  <= ev_good_q;
      frame_err_q   <= ev_ferr_q;
      sync_locked_q <= lock_q;
      if (ev_good_q) begin
        dout_q <= word_q;
      end
`ifdef S2P_FRAME_PARITY_EN
      ev_perr_q     <= 1'b0;
      parity_err_q  <= ev_perr_q;
`endif

      if (din_valid) begin
        sr_q <= shift_d[WIDTH-2:0];
        case (state_q)
          S_HUNT: begin
            // Header match only counts once two fresh bits are in hand.
            if ((cnt_q != '0) && (shift_d[1:0] == HDR)) begin
              state_q <= S_COLLECT;
              cnt_q   <= CW'(2);
            end else begin
              cnt_q   <= CW'(1);
            end
          end

          S_COLLECT: begin
            if (cnt_q == CNT_LAST) begin
              cnt_q  <= '0;
              word_q <= shift_d;
              if (hdr_ok_d) begin
`ifdef S2P_FRAME_PARITY_EN
                if (!par_ok_d) begin
                  // Parity loss leaves lock and header bookkeeping untouched.
                  ev_perr_q <= 1'b1;
                end else begin
                  ev_good_q <= 1'b1;
                  miss_q    <= '0;
                  good_q    <= good_inc_d;
                  if (good_inc_d == LOCK_C) lock_q <= 1'b1;
                end
`else
                ev_good_q <= 1'b1;
                miss_q    <= '0;
                good_q    <= good_inc_d;
                if (good_inc_d == LOCK_C) lock_q <= 1'b1;
`endif
              end else begin
                ev_ferr_q <= 1'b1;
                good_q    <= '0;
                if (!lock_q) begin
                  state_q <= S_HUNT;
                end else if ((miss_q + 3'd1) >= MISS_C) begin
                  lock_q  <= 1'b0;
                  miss_q  <= '0;
                  state_q <= S_HUNT;
                end else begin
                  miss_q  <= miss_q + 3'd1;
                end
              end
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end

          default: state_q <= S_HUNT;
        endcase
      end
    end
  end

  assign dout        = dout_q;
  assign dout_valid  = dout_valid_q;
  assign sync_locked = sync_locked_q;
  assign frame_err   = frame_err_q;
`ifdef S2P_FRAME_PARITY_EN
  assign parity_err  = parity_err_q;
`else
  assign parity_err  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_s2p_frame_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_s2p_frame_rx
// Purpose  : Self-checking bench for s2p_frame_rx. A driver streams bits and
//            feeds a bit-level reference model that keeps hunted bits and
//            frame bits in queues; frame-end verdicts (with the clock cycle
//            they must appear in) are pushed to a scoreboard, and a monitor
//            pops and compares on every dout_valid/frame_err/parity_err pulse.
// Revision : 1.0 - initial release
// ============================================================================
module tb_s2p_frame_rx;

  localparam int         WIDTH    = 16;
  localparam logic [1:0] HDR      = 2'b11;
  localparam int         LOCK_CNT = 2;
  localparam int         MISS_MAX = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             din = 1'b0;
  logic             din_valid = 1'b0;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             sync_locked;
  logic             frame_err;
  logic             parity_err;

  s2p_frame_rx #(
    .WIDTH    (WIDTH),
    .HDR      (HDR),
    .LOCK_CNT (LOCK_CNT),
    .MISS_MAX (MISS_MAX)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .din         (din),
    .din_valid   (din_valid),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .sync_locked (sync_locked),
    .frame_err   (frame_err),
    .parity_err  (parity_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  // kind: 0 = data word, 1 = frame error, 2 = parity error
  typedef struct {
    int               kind;
    logic [WIDTH-1:0] word;
    bit               locked;
    int               cyc;
  } exp_t;
  exp_t sb[$];

  // ---------------- reference model ----------------
  bit m_hunt = 1'b1;
  bit hb[$];
  bit fb[$];
  int m_good = 0;
  int m_miss = 0;
  bit m_locked = 1'b0;

  task automatic model_reset();
    m_hunt = 1'b1; hb.delete(); fb.delete();
    m_good = 0; m_miss = 0; m_locked = 1'b0;
  endtask

  task automatic frame_end(input int c);
    int   v;
    exp_t e;
    v = 0;
    foreach (fb[i]) v = v * 2 + int'(fb[i]);
    fb.delete();
    e.word = v[WIDTH-1:0];
    e.cyc  = c + 2;
    if ((v / (1 << (WIDTH - 2))) == int'(HDR)) begin
`ifdef S2P_FRAME_PARITY_EN
      if (($countones(v) % 2) != 0) begin
        e.kind = 2; e.locked = m_locked; sb.push_back(e);
        return;
      end
`endif
      m_miss = 0;
      m_good = (m_good + 1 > LOCK_CNT) ? LOCK_CNT : m_good + 1;
      if (m_good == LOCK_CNT) m_locked = 1'b1;
      e.kind = 0;
    end else begin
      m_good = 0;
      if (!m_locked) begin
        m_hunt = 1'b1;
      end else begin
        m_miss++;
        if (m_miss == MISS_MAX) begin
          m_locked = 1'b0; m_miss = 0; m_hunt = 1'b1;
        end
      end
      e.kind = 1;
    end
    e.locked = m_locked;
    sb.push_back(e);
  endtask

  task automatic model_bit(input bit b, input int c);
    if (m_hunt) begin
      hb.push_back(b);
      if (hb.size() >= 2 && hb[hb.size()-2] == HDR[1] && hb[hb.size()-1] == HDR[0]) begin
        m_hunt = 1'b0;
        hb.delete();
        fb.push_back(HDR[1]);
        fb.push_back(HDR[0]);
      end
    end else begin
      fb.push_back(b);
      if (fb.size() == WIDTH) frame_end(c);
    end
  endtask

  // ---------------- driver tasks (entered just after a rising edge) -------
  task automatic send_bit(input bit b, input int gaps);
    for (int g = 0; g < gaps; g++) begin
      din_valid = 1'b0;
      din = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    din_valid = 1'b1;
    din = b;
    model_bit(b, cyc);
    @(posedge clk); #1;
    din_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [WIDTH-1:0] w, input int gaps);
    for (int i = WIDTH - 1; i >= 0; i--) send_bit(w[i], gaps);
  endtask

  task automatic idle(input int n);
    din_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (dout !== '0 || dout_valid !== 1'b0 || sync_locked !== 1'b0 ||
        frame_err !== 1'b0 || parity_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got dout=%h dv=%b lock=%b ferr=%b perr=%b, want all 0",
               dout, dout_valid, sync_locked, frame_err, parity_err);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (dout_valid && frame_err) begin
        n_checks++; n_fail++;
        $display("FAIL dv_ferr_exclusive: both high at cycle %0d", cyc);
      end
      if (dout_valid || frame_err || parity_err) begin
        int   k;
        exp_t e;
        k = dout_valid ? 0 : (frame_err ? 1 : 2);
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_event: kind=%0d dout=%h at cycle %0d, none expected",
                   k, dout, cyc);
        end else begin
          e = sb.pop_front();
          if (k != e.kind || (e.kind == 0 && dout !== e.word) ||
              sync_locked !== e.locked || cyc != e.cyc) begin
            n_fail++;
            $display("FAIL event: got kind=%0d dout=%h lock=%b cyc=%0d, want kind=%0d dout=%h lock=%b cyc=%0d",
                     k, dout, sync_locked, cyc, e.kind, e.word, e.locked, e.cyc);
          end
        end
      end
    end
  end

  task automatic drain_and_check(input string tag);
    for (int i = 0; i < 20 && sb.size() > 0; i++) begin
      @(posedge clk); #1;
    end
    idle(2);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain_%s: %0d expected events never seen, want 0", tag, sb.size());
      sb.delete();
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    @(posedge clk); #1;
    do_reset();

    // Single frame, then back-to-back frames; lock rises with the 2nd good one.
    send_frame(16'hC123, 0);
    send_frame(16'hD00F, 0);
    send_frame(16'hFFFF, 0);
    send_frame(16'hC3C3, 0);
    // Two bad headers while locked: lock lost, then re-acquire.
    send_frame(16'h4000, 0);
    send_frame(16'h4000, 0);
    send_frame(16'hC0A5, 0);
    drain_and_check("directed");

    // din_valid toggling every cycle.
    send_frame(16'hC123, 1);
    drain_and_check("toggle");

    // Reset mid-frame after 7 bits, then a full frame.
    for (int i = WIDTH - 1; i > WIDTH - 8; i--) send_bit(1'b1, 0);
    do_reset();
    send_frame(16'hE001, 0);
    drain_and_check("midreset");

    // Parity samples (plain data frames when the parity option is off).
    send_frame(16'hC001, 0);
    send_frame(16'hC003, 0);
    drain_and_check("parity");

    // Randomized traffic: mostly good headers, random gaps and junk bits.
    for (int f = 0; f < 250; f++) begin
      logic [WIDTH-1:0] w;
      int               gaps;
      w = WIDTH'($urandom);
      if ($urandom_range(0, 99) < 85) w[WIDTH-1:WIDTH-2] = HDR;
      gaps = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
      if ($urandom_range(0, 19) == 0) begin
        int nj;
        nj = int'($urandom_range(1, 3));
        for (int j = 0; j < nj; j++) send_bit(1'($urandom_range(0, 1)), 0);
      end
      send_frame(w, gaps);
    end
    drain_and_check("random");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, want completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
